fifo_burst_reader: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 15 +
 rtl/fifo_burst_reader_out_stage.sv | 42 ++++
 rtl/fifo_burst_reader.sv | 172 +++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizing for the FIFO burst reader.
package fifo_rd_pkg;

  localparam int unsigned WIDTH_DEF       = 16;
  localparam int unsigned LEN_W_DEF       = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_burst_reader_out_stage.sv
// Registered valid/ready output slice: loads a word on i_load, holds it until accepted.
module fifo_out_stage
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;

  // Load wins over accept so back-to-back pops stream at one word per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read engine for a show-ahead sync FIFO: pops len words and streams them out.
// Optional starvation abort is enabled by defining FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned LEN_W       = LEN_W_DEF
`ifdef FIFO_BURST_READER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
`ifdef FIFO_BURST_READER_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  state_e           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             w_pop;
  logic             w_last;
  logic             w_accept;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_starve;
  logic             r_abort;
  logic             r_timeout_err;
  logic             w_starve_hit;
`endif

  // Pop only when a word is owed, available, and the output slot is free; suppressed in reset
  // so a reset never consumes a word from the FIFO.
  always_comb begin
    w_pop    = (r_state == READ) && (r_remaining != '0) && !fifo_empty &&
               (!m_valid || m_ready) && !rst;
    w_last   = (r_remaining == LEN_W'(1));
    w_accept = m_valid && m_ready;
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  // Starvation counter: counts empty cycles while words are still owed, clears on any pop.
  always_ff @(posedge clk) begin
    if (rst || w_pop || (r_state != READ)) begin
      r_starve <= '0;
    end else if (fifo_empty && (r_remaining != '0)) begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end

  always_comb begin
    w_starve_hit = (r_state == READ) && (r_remaining != '0) && fifo_empty &&
                   (r_starve == CNT_W'(TIMEOUT_CYC - 1));
  end
`endif

  // Burst control FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
      r_abort       <= 1'b0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      if (w_pop) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (len != '0) begin
              r_remaining <= len;
              r_state     <= READ;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          // All words popped: the final one is on the output slot.
          if (r_remaining == '0) begin
            if (w_accept) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
          else if (w_starve_hit) begin
            r_remaining <= '0;
            if (m_valid && !m_ready) begin
              r_state <= DRAIN;
              r_abort <= 1'b1;
            end else begin
              r_state       <= DONE;
              r_done        <= 1'b1;
              r_timeout_err <= 1'b1;
            end
          end
`endif
        end
        DRAIN: begin
          if (w_accept) begin
            r_state <= DONE;
            r_done  <= 1'b1;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            r_timeout_err <= r_abort;
            r_abort       <= 1'b0;
`endif
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  fifo_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_pop),
    .i_data  (fifo_rd_data),
    .i_last  (w_last),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_last  (m_last)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign fifo_rd_en = w_pop;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural model plus directed bursts.
module tb_fifo_burst_reader;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int TOUT = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic        fifo_empty;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_ready;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
  logic        timeout_err;
`endif

  fifo_burst_reader #(
    .WIDTH       (16),
    .LEN_W       (8)
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TOUT)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready)
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: writer owns wr_ptr/mem, reader process owns rd_ptr.
  logic [15:0] mem [0:63];
  logic [31:0] wr_ptr = 32'd0;
  logic [31:0] rd_ptr = 32'd0;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = mem[rd_ptr[5:0]];

  int checks = 0;
  int errors = 0;

  // Observation log
  int          cyc = 0;
  int          pop_n = 0;
  int          got_n = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  int          terr_n = 0;
  int          pop_cyc [0:255];
  logic [15:0] got [0:255];
  bit          got_last [0:255];

  // Behavioural model of the burst contract
  bit          md_active = 1'b0;
  bit          md_done = 1'b0;
  bit          md_terr = 1'b0;
  bit          md_ab = 1'b0;
  int          md_left = 0;
  int          md_st = 0;
  bit          md_v = 1'b0;
  bit          md_l = 1'b0;
  logic [15:0] md_d = 16'h0;

  function automatic bit exp_pop();
    return md_active && (md_left != 0) && (wr_ptr != rd_ptr) && (!md_v || m_ready) && !rst;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Model step and observation at every rising edge.
  always @(posedge clk) begin
    bit p;
    bit acc;
    int old_left;
    p        = exp_pop();
    acc      = md_v && m_ready;
    old_left = md_left;
    if (rst) begin
      md_active = 0; md_done = 0; md_terr = 0; md_ab = 0;
      md_left = 0; md_st = 0; md_v = 0; md_l = 0; md_d = 16'h0;
    end else begin
      md_terr = 0;
      if (p) begin
        md_v = 1; md_d = mem[rd_ptr[5:0]]; md_l = (md_left == 1); md_left--;
      end else if (acc) begin
        md_v = 0; md_l = 0;
      end
      if (md_done) begin
        md_done = 0;
      end else if (!md_active) begin
        if (start) begin
          if (len == 8'd0) md_done = 1;
          else begin md_active = 1; md_left = int'(len); md_st = 0; end
        end
      end else if (old_left == 0) begin
        if (acc) begin md_active = 0; md_done = 1; md_terr = md_ab; md_ab = 0; end
      end else if (p) begin
        md_st = 0;
      end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
      else if (wr_ptr == rd_ptr) begin
        if (md_st == TOUT - 1) begin
          md_left = 0; md_st = 0;
          if (md_v && !m_ready) md_ab = 1;
          else begin md_active = 0; md_done = 1; md_terr = 1; end
        end else begin
          md_st++;
        end
      end
`endif
    end
    cyc++;
    if (fifo_rd_en) begin pop_cyc[pop_n] = cyc; pop_n++; rd_ptr <= rd_ptr + 32'd1; end
    if (m_valid && m_ready) begin got[got_n] = m_data; got_last[got_n] = m_last; got_n++; end
    if (done) begin done_n++; done_cyc = cyc; end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    if (done && timeout_err) terr_n++;
`endif
  end

  // Cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("busy",       32'(busy),       32'(md_active | md_done));
    chk("done",       32'(done),       32'(md_done));
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_pop()));
    chk("m_valid",    32'(m_valid),    32'(md_v));
    chk("m_data",     32'(m_data),     32'(md_d));
    chk("m_last",     32'(m_last),     32'(md_l));
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    chk("timeout_err", 32'(timeout_err), 32'(md_terr));
`endif
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 32'd1;
  endtask

  task automatic wait_done(input int base, input int bound, input string nm);
    for (int i = 0; i < bound && done_n == base; i++) step(1);
    chk(nm, 32'(done_n - base), 32'd1);
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1; len = l;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int bg, bp, bd, nlast;
    rst = 1'b1; start = 1'b0; len = 8'd0; m_ready = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);

    // Basic burst of four at full throughput
    for (int i = 1; i <= 4; i++) push(16'(i));
    bg = got_n; bp = pop_n; bd = done_n;
    pulse_start(8'd4);
    wait_done(bd, 30, "basic_done");
    chk("basic_busy_fall", 32'(busy), 32'd0);
    chk("basic_pops", 32'(pop_n - bp), 32'd4);
    chk("basic_pop_span", 32'(pop_cyc[bp+3] - pop_cyc[bp]), 32'd3);
    chk("basic_done_lat", 32'(done_cyc - pop_cyc[bp]), 32'd5);
    chk("basic_words", 32'(got_n - bg), 32'd4);
    for (int i = 0; i < 4; i++) chk("basic_word", 32'(got[bg+i]), 32'(i + 1));
    nlast = 0;
    for (int i = 0; i < 4; i++) nlast += int'(got_last[bg+i]);
    chk("basic_nlast", 32'(nlast), 32'd1);
    chk("basic_last4", 32'(got_last[bg+3]), 32'd1);

    // Backpressure 1,0,0 repeating
    push(16'h0011); push(16'h0022); push(16'h0033);
    bg = got_n; bd = done_n;
    for (int k = 0; k < 60 && done_n == bd; k++) begin
      m_ready = (k % 3 == 0);
      start   = (k == 0);
      len     = 8'd3;
      step(1);
    end
    start = 1'b0; m_ready = 1'b1;
    chk("bp_done", 32'(done_n - bd), 32'd1);
    chk("bp_words", 32'(got_n - bg), 32'd3);
    chk("bp_w0", 32'(got[bg]),   32'h0011);
    chk("bp_w1", 32'(got[bg+1]), 32'h0022);
    chk("bp_w2", 32'(got[bg+2]), 32'h0033);
    chk("bp_last", 32'(got_last[bg+2]), 32'd1);

    // Starvation: two words ready, three arrive ten cycles later
    push(16'h00A1); push(16'h00A2);
    bg = got_n; bp = pop_n; bd = done_n;
    for (int k = 0; k < 80 && done_n == bd; k++) begin
      start = (k == 0);
      len   = 8'd5;
      if (k == 10) begin push(16'h00A3); push(16'h00A4); push(16'h00A5); end
      step(1);
    end
    start = 1'b0;
    chk("starve_done", 32'(done_n - bd), 32'd1);
    chk("starve_pops", 32'(pop_n - bp), 32'd5);
    chk("starve_words", 32'(got_n - bg), 32'd5);
    for (int i = 0; i < 5; i++) chk("starve_word", 32'(got[bg+i]), 32'(16'h00A1 + 16'(i)));
    chk("starve_last5", 32'(got_last[bg+4]), 32'd1);

    // Zero length: done without any pop
    bp = pop_n;
    pulse_start(8'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    step(1);
    chk("zero_done_fall", 32'(done), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);
    chk("zero_pops", 32'(pop_n - bp), 32'd0);

    // start while busy is ignored
    for (int i = 0; i < 4; i++) push(16'h00B1 + 16'(i));
    bg = got_n; bp = pop_n; bd = done_n;
    pulse_start(8'd4);
    step(1);
    pulse_start(8'd2);
    wait_done(bd, 30, "busy_start_done");
    step(3);
    chk("busy_start_idle", 32'(busy), 32'd0);
    chk("busy_start_pops", 32'(pop_n - bp), 32'd4);
    chk("busy_start_words", 32'(got_n - bg), 32'd4);
    chk("busy_start_w3", 32'(got[bg+3]), 32'h00B4);

    // Reset after three pops of an eight-word burst
    for (int i = 0; i < 8; i++) push(16'h00C1 + 16'(i));
    bp = pop_n;
    pulse_start(8'd8);
    for (int i = 0; i < 20 && (pop_n - bp) < 3; i++) step(1);
    chk("rst_mid_pops", 32'(pop_n - bp), 32'd3);
    rst = 1'b1;
    step(1);
    chk("rst_mid_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_data", 32'(m_data), 32'd0);
    chk("rst_mid_last", 32'(m_last), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_left", 32'(wr_ptr - rd_ptr), 32'd5);
    rst = 1'b0;
    step(1);
    bg = got_n; bd = done_n;
    pulse_start(8'd5);
    wait_done(bd, 30, "rst_resume_done");
    chk("rst_resume_words", 32'(got_n - bg), 32'd5);
    for (int i = 0; i < 5; i++) chk("rst_resume_word", 32'(got[bg+i]), 32'(16'h00C4 + 16'(i)));
    chk("rst_resume_empty", 32'(wr_ptr - rd_ptr), 32'd0);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // Starved burst aborts after the limit
    push(16'h00D1);
    bg = got_n; bp = pop_n; bd = done_n;
    pulse_start(8'd4);
    wait_done(bd, 60, "tout_done");
    chk("tout_err", 32'(terr_n), 32'd1);
    chk("tout_words", 32'(got_n - bg), 32'd1);
    chk("tout_word", 32'(got[bg]), 32'h00D1);
    chk("tout_nolast", 32'(got_last[bg]), 32'd0);
    chk("tout_lat", 32'(done_cyc - pop_cyc[bp]), 32'(TOUT + 1));
`endif

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
